// File: rtl/mmio_timer_responder.sv
// ----------------------------------------------------------------------------
// mmio_timer_responder
//
// Memory-mapped peripheral on the core's data-memory bus. It holds a display
// register, a prescaled 32-bit up-counter with a compare value and a sticky
// match flag, and a level interrupt built from that flag.
//
// Register window (32 bytes, word access only, A[1:0] ignored):
//    0x00 DISPLAY  rw
//    0x04 COUNT    rw
//    0x08 CMP      rw
//    0x0C CTRL     rw  [0]=enable [1]=auto_reload [2]=irq_en, upper bits read 0
//    0x10 STATUS   bit0 match, write-1-to-clear, upper bits read 0
//    0x14..0x1C    reserved, read 0, writes ignored
//
// Parameters:
//    BASE_ADDR      byte base of the window, aligned to 32
//    PRESCALE       clocks per timer tick, must be >= 1 (1 = tick every clock)
//    RESET_DISPLAY  reset value of DISPLAY
//
// Ports:
//    clk           rising-edge clock
//    reset         asynchronous, active-low reset
//    A             byte address from the core
//    WD            write data from the core
//    WE            write enable from the core
//    RD            read data, combinational, 0 when the window is not hit
//    hit           A lies inside the register window
//    display_data  current DISPLAY register
//    irq           STATUS.match AND CTRL.irq_en
// ----------------------------------------------------------------------------
module mmio_timer_responder #(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0400,
   parameter int unsigned PRESCALE      = 16,
   parameter logic [31:0] RESET_DISPLAY = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic        WE,
   output logic [31:0] RD,
   output logic        hit,
   output logic [31:0] display_data,
   output logic        irq
);

   // A prescaler of one still needs a one-bit register so the design elaborates.
   localparam int unsigned      PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   localparam logic [2:0] OFF_DISPLAY = 3'd0;
   localparam logic [2:0] OFF_COUNT   = 3'd1;
   localparam logic [2:0] OFF_CMP     = 3'd2;
   localparam logic [2:0] OFF_CTRL    = 3'd3;
   localparam logic [2:0] OFF_STATUS  = 3'd4;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_IRQEN  = 2;

   logic [31:0]      display_q, display_d;
   logic [31:0]      count_q, count_d;
   logic [31:0]      cmp_q, cmp_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic             match_q, match_d;
   logic [PRE_W-1:0] prescaleCnt_q, prescaleCnt_d;

   logic [2:0]  offset;
   logic        wrEn;
   logic        tick;
   logic        countHit;
   logic [31:0] rdData;

   // Byte lanes are never selected individually, so the low address bits
   // carry no information for this block.
   logic unusedAddrBits;
   assign unusedAddrBits = ^A[1:0];

   // Address decode: the window is 32-byte aligned, so the upper 27 bits
   // identify it and A[4:2] picks the word inside it.
   assign hit    = (A[31:5] == BASE_ADDR[31:5]);
   assign offset = A[4:2];
   assign wrEn   = WE & hit;

   // Prescaler: runs 0..PRESCALE-1 only while enabled and produces a tick on
   // its last count. Disabling parks it at zero so the next enable always
   // starts a full prescale period.
   always_comb begin
      tick          = 1'b0;
      prescaleCnt_d = prescaleCnt_q;
      if (!ctrl_q[CTRL_ENABLE]) begin
         prescaleCnt_d = '0;
      end else if (prescaleCnt_q == PRE_MAX) begin
         tick          = 1'b1;
         prescaleCnt_d = '0;
      end else begin
         prescaleCnt_d = prescaleCnt_q + PRE_W'(1);
      end
   end

   // The compare always uses the registered CMP, so a CMP write landing on a
   // tick edge only affects later ticks.
   assign countHit = (count_q == cmp_q);

   // Register next-state. A software write to COUNT overrides the tick
   // increment on the same edge. A W1C on STATUS loses against a match being
   // raised on the same edge so that no match event is ever dropped. A CTRL
   // write that clears enable still lets the current tick through because
   // the tick was computed from the old CTRL value.
   always_comb begin
      display_d = display_q;
      count_d   = count_q;
      cmp_d     = cmp_q;
      ctrl_d    = ctrl_q;
      match_d   = match_q;

      if (tick) begin
         if (countHit && ctrl_q[CTRL_RELOAD]) begin
            count_d = 32'd0;
         end else begin
            count_d = count_q + 32'd1;
         end
      end

      if (wrEn) begin
         case (offset)
            OFF_DISPLAY: display_d = WD;
            OFF_COUNT:   count_d   = WD;
            OFF_CMP:     cmp_d     = WD;
            OFF_CTRL:    ctrl_d    = WD[2:0];
            OFF_STATUS: begin
               if (WD[0]) begin
                  match_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      if (tick && countHit) begin
         match_d = 1'b1;
      end
   end

   // State registers. Reset abandons any partial prescale period and puts
   // CMP at all-ones so a freshly enabled timer does not match immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         display_q     <= RESET_DISPLAY;
         count_q       <= 32'd0;
         cmp_q         <= 32'hFFFF_FFFF;
         ctrl_q        <= 3'b000;
         match_q       <= 1'b0;
         prescaleCnt_q <= '0;
      end else begin
         display_q     <= display_d;
         count_q       <= count_d;
         cmp_q         <= cmp_d;
         ctrl_q        <= ctrl_d;
         match_q       <= match_d;
         prescaleCnt_q <= prescaleCnt_d;
      end
   end

   // Read mux: purely combinational so the single-cycle core sees the data
   // in the same cycle it presents the address. Outside the window the bus
   // is driven to zero so the top-level mux can simply OR or select.
   always_comb begin
      rdData = 32'd0;
      if (hit) begin
         case (offset)
            OFF_DISPLAY: rdData = display_q;
            OFF_COUNT:   rdData = count_q;
            OFF_CMP:     rdData = cmp_q;
            OFF_CTRL:    rdData = {29'd0, ctrl_q};
            OFF_STATUS:  rdData = {31'd0, match_q};
            default:     rdData = 32'd0;
         endcase
      end
   end

   assign RD           = rdData;
   assign display_data = display_q;
   assign irq          = match_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_mmio_timer_responder.sv
// ----------------------------------------------------------------------------
// tb_mmio_timer_responder
//
// Drives the bus one cycle at a time. A behavioural reference of the register
// file predicts every read; the prediction is queued when the address is
// driven and compared when RD is sampled on the falling edge. Directed steps
// additionally compare key reads against hand-derived constants.
// ----------------------------------------------------------------------------
module tb_mmio_timer_responder;

   localparam logic [31:0] BASE     = 32'h0000_0400;
   localparam int          PRESC    = 4;
   localparam logic [31:0] RST_DISP = 32'hA5A5_0001;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;
   logic        hit;
   logic [31:0] display_data;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] expQ[$];

   mmio_timer_responder #(
      .BASE_ADDR    (BASE),
      .PRESCALE     (PRESC),
      .RESET_DISPLAY(RST_DISP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .A           (A),
      .WD          (WD),
      .WE          (WE),
      .RD          (RD),
      .hit         (hit),
      .display_data(display_data),
      .irq         (irq)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net in case the run ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference register file, updated on the same edges as the DUT.
   logic [31:0] mDisplay;
   logic [31:0] mCount;
   logic [31:0] mCmp;
   logic [2:0]  mCtrl;
   logic        mMatch;
   int          mPre;

   logic        mTick;
   logic        mWr;
   logic [2:0]  mOff;

   assign mTick = mCtrl[0] && (mPre == PRESC - 1);
   assign mWr   = WE && (A[31:5] == BASE[31:5]);
   assign mOff  = A[4:2];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mDisplay <= RST_DISP;
         mCount   <= 32'd0;
         mCmp     <= 32'hFFFF_FFFF;
         mCtrl    <= 3'b000;
         mMatch   <= 1'b0;
         mPre     <= 0;
      end else begin
         if (!mCtrl[0] || mTick) mPre <= 0;
         else                    mPre <= mPre + 1;
         if (mWr && mOff == 3'd0) mDisplay <= WD;
         if (mWr && mOff == 3'd2) mCmp <= WD;
         if (mWr && mOff == 3'd3) mCtrl <= WD[2:0];
         if (mWr && mOff == 3'd1)  mCount <= WD;
         else if (mTick)           mCount <= (mCount == mCmp && mCtrl[1]) ? 32'd0 : mCount + 32'd1;
         if (mTick && mCount == mCmp)             mMatch <= 1'b1;
         else if (mWr && mOff == 3'd4 && WD[0])   mMatch <= 1'b0;
      end
   end

   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      logic [31:0] v;
      v = 32'd0;
      if (addr[31:5] == BASE[31:5]) begin
         case (addr[4:2])
            3'd0: v = mDisplay;
            3'd1: v = mCount;
            3'd2: v = mCmp;
            3'd3: v = {29'd0, mCtrl};
            3'd4: v = {31'd0, mMatch};
            default: v = 32'd0;
         endcase
      end
      return v;
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, queue the predicted read, compare on the falling
   // edge, then step past the rising edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                                output logic [31:0] rdObs, output logic irqObs);
      logic expHit;
      A  = addr;
      WD = wdata;
      WE = we;
      expQ.push_back(modelRead(addr));
      expHit = (addr[31:5] == BASE[31:5]);
      @(negedge clk);
      checkOutput("rd_model", RD, expQ.pop_front());
      checkOutput("hit", {31'd0, hit}, {31'd0, expHit});
      checkOutput("irq_model", {31'd0, irq}, {31'd0, mMatch & mCtrl[2]});
      checkOutput("display_model", display_data, mDisplay);
      rdObs  = RD;
      irqObs = irq;
      @(posedge clk);
      #1;
      WE = 1'b0;
   endtask

   task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] r;
      logic        q;
      applyStimulus(addr, data, 1'b1, r, q);
   endtask

   task automatic readExpect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      logic        q;
      applyStimulus(addr, 32'd0, 1'b0, r, q);
      checkOutput(tag, r, exp);
   endtask

   task automatic readIrqExpect(input string tag, input logic [31:0] addr, input logic expIrq);
      logic [31:0] r;
      logic        q;
      applyStimulus(addr, 32'd0, 1'b0, r, q);
      checkOutput(tag, {31'd0, q}, {31'd0, expIrq});
   endtask

   task automatic idle(input int n);
      logic [31:0] r;
      logic        q;
      for (int i = 0; i < n; i++) applyStimulus(32'h0000_0000, 32'd0, 1'b0, r, q);
   endtask

   // Asynchronous reset asserted between edges; outputs are checked while it
   // is held, then it is released just after a rising edge.
   task automatic doReset();
      reset = 1'b0;
      A     = BASE + 32'h4;
      WE    = 1'b0;
      WD    = 32'd0;
      @(negedge clk);
      checkOutput("reset_rd_count", RD, 32'd0);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      checkOutput("reset_display", display_data, RST_DISP);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      A     = 32'd0;
      WD    = 32'd0;
      WE    = 1'b0;
      #2;
      doReset();

      // Reset contents.
      readExpect("reset_cmp", BASE + 32'h8, 32'hFFFF_FFFF);
      readExpect("reset_status", BASE + 32'h10, 32'd0);
      readExpect("miss_rd", 32'h0000_0000, 32'd0);

      // Display register, out-of-window write, reserved and CTRL upper bits.
      writeReg(BASE + 32'h0, 32'hDEAD_BEEF);
      readExpect("display_read", BASE + 32'h0, 32'hDEAD_BEEF);
      writeReg(BASE + 32'h20, 32'h1111_2222);
      readExpect("display_after_miss", BASE + 32'h0, 32'hDEAD_BEEF);
      readExpect("miss_0x20_rd", BASE + 32'h20, 32'd0);
      writeReg(BASE + 32'h18, 32'h5555_5555);
      readExpect("reserved_rd", BASE + 32'h18, 32'd0);
      writeReg(BASE + 32'hC, 32'hFFFF_FFF8);
      readExpect("ctrl_upper", BASE + 32'hC, 32'd0);
      readExpect("byte_offset_ignored", BASE + 32'h3, 32'hDEAD_BEEF);

      // Timer with compare: CMP=3, irq_en+enable, one tick every 4 edges.
      writeReg(BASE + 32'h8, 32'd3);
      writeReg(BASE + 32'hC, 32'h5);
      idle(12);
      readExpect("t3_count_at12", BASE + 32'h4, 32'd3);
      readIrqExpect("t3_status_at13", BASE + 32'h10, 1'b0);
      idle(3);
      readExpect("t3_status_at16", BASE + 32'h10, 32'd1);
      readIrqExpect("t3_irq_at17", BASE + 32'h4, 1'b1);
      readExpect("t3_count_at18", BASE + 32'h4, 32'd4);

      // Reset in the middle of a running timer.
      idle(2);
      doReset();
      readExpect("t1_count_after_reset", BASE + 32'h4, 32'd0);

      // Auto-reload with CMP=2: 0,1,2,0,1,2 in steps of four edges.
      writeReg(BASE + 32'h8, 32'd2);
      writeReg(BASE + 32'hC, 32'h3);
      for (int i = 0; i < 24; i++) readExpect("t4_count", BASE + 32'h4, 32'((i / 4) % 3));
      readExpect("t4_match", BASE + 32'h10, 32'd1);
      writeReg(BASE + 32'h10, 32'd1);
      readExpect("t4_w1c", BASE + 32'h10, 32'd0);

      // Same-edge collisions.
      doReset();
      writeReg(BASE + 32'h8, 32'd0);
      writeReg(BASE + 32'hC, 32'h5);
      idle(3);
      writeReg(BASE + 32'h10, 32'd1);
      readIrqExpect("t5_irq_set_wins", BASE + 32'h10, 1'b1);
      idle(2);
      writeReg(BASE + 32'h4, 32'h100);
      readExpect("t5_count_write_wins", BASE + 32'h4, 32'h100);
      writeReg(BASE + 32'h10, 32'd0);
      readExpect("t5_write0_no_effect", BASE + 32'h10, 32'd1);
      writeReg(BASE + 32'h10, 32'd1);
      readExpect("t5_w1c_clear", BASE + 32'h10, 32'd0);

      // Counter wrap without a match.
      doReset();
      writeReg(BASE + 32'h4, 32'hFFFF_FFFF);
      writeReg(BASE + 32'h8, 32'd5);
      writeReg(BASE + 32'hC, 32'h1);
      idle(3);
      readExpect("t6_count_pre_wrap", BASE + 32'h4, 32'hFFFF_FFFF);
      readExpect("t6_count_wrapped", BASE + 32'h4, 32'd0);
      readExpect("t6_no_match", BASE + 32'h10, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
